// File: rtl/jelly2_wb_pwm_gpio.sv
// WISHBONE PWM block: shared prescaler/period counter, N channels with duty and
// polarity. Period and duty are double-buffered and load on wrap, force or idle.
module jelly2_wb_pwm_gpio #(
    parameter int unsigned WB_ADR_WIDTH = 16,
    parameter int unsigned WB_DAT_WIDTH = 32,
    parameter int unsigned N            = 4,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned PRE_WIDTH    = 16,
    parameter logic [31:0] CORE_ID      = 32'h527a_0310
) (
    input  logic                      reset,
    input  logic                      clk,
    input  logic                      cke,
    input  logic [WB_ADR_WIDTH-1:0]   s_wb_adr_i,
    input  logic [WB_DAT_WIDTH-1:0]   s_wb_dat_i,
    output logic [WB_DAT_WIDTH-1:0]   s_wb_dat_o,
    input  logic [WB_DAT_WIDTH/8-1:0] s_wb_sel_i,
    input  logic                      s_wb_we_i,
    input  logic                      s_wb_stb_i,
    output logic                      s_wb_ack_o,
    output logic [N-1:0]              pwm_out
);

    logic                 enable_q,     enable_d;
    logic [PRE_WIDTH-1:0] prescale_q,   prescale_d;
    logic [CNT_WIDTH-1:0] period_q,     period_d;
    logic [N-1:0]         invert_q,     invert_d;
    logic [CNT_WIDTH-1:0] duty_q [N];
    logic [CNT_WIDTH-1:0] duty_d [N];
    logic [CNT_WIDTH-1:0] act_period_q, act_period_d;
    logic [CNT_WIDTH-1:0] act_duty_q [N];
    logic [CNT_WIDTH-1:0] act_duty_d [N];
    logic [PRE_WIDTH-1:0] pre_cnt_q,    pre_cnt_d;
    logic [CNT_WIDTH-1:0] counter_q,    counter_d;
    logic [N-1:0]         pwm_q,        pwm_d;

    logic [3:0]  adr4;
    logic        wr_en;
    logic        tick;
    logic        wrap;
    logic        force_upd;
    logic [31:0] wr_m;
    logic [31:0] rdata;
    logic        adr_unused;

    function automatic logic [31:0] merge_wr(input logic [31:0] cur,
                                             input logic [31:0] dat,
                                             input logic [3:0]  sel);
        logic [31:0] r;
        r = cur;
        for (int unsigned k = 0; k < 4; k++) begin
            if (sel[k]) r[8*k +: 8] = dat[8*k +: 8];
        end
        return r;
    endfunction

    assign adr4       = s_wb_adr_i[3:0];
    assign adr_unused = ^s_wb_adr_i[WB_ADR_WIDTH-1:4];
    assign wr_en      = s_wb_stb_i && s_wb_we_i;
    assign tick       = enable_q && cke && (pre_cnt_q == prescale_q);
    assign wrap       = tick && (counter_q == act_period_q);
    assign force_upd  = wr_en && (adr4 == 4'h1) && s_wb_sel_i[0] && s_wb_dat_i[1];

    always_comb begin
        enable_d     = enable_q;
        prescale_d   = prescale_q;
        period_d     = period_q;
        invert_d     = invert_q;
        duty_d       = duty_q;
        act_period_d = act_period_q;
        act_duty_d   = act_duty_q;
        pre_cnt_d    = pre_cnt_q;
        counter_d    = counter_q;
        pwm_d        = pwm_q;
        wr_m         = '0;

        if (!enable_q) begin
            pre_cnt_d = '0;
            counter_d = '0;
        end else if (cke) begin
            if (tick) begin
                pre_cnt_d = '0;
                counter_d = wrap ? '0 : counter_q + CNT_WIDTH'(1);
            end else begin
                pre_cnt_d = pre_cnt_q + PRE_WIDTH'(1);
            end
        end

        // Transfer samples the pending registers before this cycle's bus write.
        if (wrap || force_upd || !enable_q) begin
            act_period_d = period_q;
            act_duty_d   = duty_q;
        end

        if (cke) begin
            for (int unsigned i = 0; i < N; i++) begin
                pwm_d[i] = (enable_q && (counter_q < act_duty_q[i])) ^ invert_q[i];
            end
        end

        if (wr_en) begin
            case (adr4)
                4'h1: begin
                    wr_m     = merge_wr(32'(enable_q), s_wb_dat_i, s_wb_sel_i);
                    enable_d = wr_m[0];
                end
                4'h3: begin
                    wr_m       = merge_wr(32'(prescale_q), s_wb_dat_i, s_wb_sel_i);
                    prescale_d = wr_m[PRE_WIDTH-1:0];
                end
                4'h4: begin
                    wr_m     = merge_wr(32'(period_q), s_wb_dat_i, s_wb_sel_i);
                    period_d = wr_m[CNT_WIDTH-1:0];
                end
                4'h6: begin
                    wr_m     = merge_wr(32'(invert_q), s_wb_dat_i, s_wb_sel_i);
                    invert_d = wr_m[N-1:0];
                end
                default: begin
                    for (int unsigned i = 0; i < N; i++) begin
                        if (adr4 == 4'(8 + i)) begin
                            wr_m      = merge_wr(32'(duty_q[i]), s_wb_dat_i, s_wb_sel_i);
                            duty_d[i] = wr_m[CNT_WIDTH-1:0];
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q     <= 1'b0;
            prescale_q   <= '0;
            period_q     <= '0;
            invert_q     <= '0;
            act_period_q <= '0;
            pre_cnt_q    <= '0;
            counter_q    <= '0;
            pwm_q        <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                duty_q[i]     <= '0;
                act_duty_q[i] <= '0;
            end
        end else begin
            enable_q     <= enable_d;
            prescale_q   <= prescale_d;
            period_q     <= period_d;
            invert_q     <= invert_d;
            act_period_q <= act_period_d;
            pre_cnt_q    <= pre_cnt_d;
            counter_q    <= counter_d;
            pwm_q        <= pwm_d;
            duty_q       <= duty_d;
            act_duty_q   <= act_duty_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (adr4)
            4'h0:       rdata = CORE_ID;
            4'h1, 4'h2: rdata = 32'(enable_q);
            4'h3:       rdata = 32'(prescale_q);
            4'h4:       rdata = 32'(period_q);
            4'h5:       rdata = 32'(counter_q);
            4'h6:       rdata = 32'(invert_q);
            default: begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (adr4 == 4'(8 + i)) rdata = 32'(duty_q[i]);
                end
            end
        endcase
    end

    assign s_wb_dat_o = rdata;
    assign s_wb_ack_o = s_wb_stb_i;
    assign pwm_out    = pwm_q;

endmodule

// File: tb/tb_jelly2_wb_pwm_gpio.sv
// Randomized bench for jelly2_wb_pwm_gpio against a cycle-level behavioural model
// plus directed waveform checks computed from the register settings.
module tb_jelly2_wb_pwm_gpio;

    logic        clk = 1'b0;
    logic        reset, cke;
    logic [15:0] adr;
    logic [31:0] dat_i, dat_o;
    logic [3:0]  sel;
    logic        we, stb, ack;
    logic [3:0]  pwm;

    jelly2_wb_pwm_gpio #(
        .WB_ADR_WIDTH (16),
        .WB_DAT_WIDTH (32),
        .N            (4),
        .CNT_WIDTH    (16),
        .PRE_WIDTH    (16),
        .CORE_ID      (32'h527a_0310)
    ) dut (
        .reset      (reset),
        .clk        (clk),
        .cke        (cke),
        .s_wb_adr_i (adr),
        .s_wb_dat_i (dat_i),
        .s_wb_dat_o (dat_o),
        .s_wb_sel_i (sel),
        .s_wb_we_i  (we),
        .s_wb_stb_i (stb),
        .s_wb_ack_o (ack),
        .pwm_out    (pwm)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference model state
    logic        m_en;
    logic [31:0] m_pre, m_per, m_pc, m_cnt, a_per;
    logic [3:0]  m_inv, m_pwm;
    logic [31:0] m_duty [4];
    logic [31:0] a_duty [4];

    function automatic logic [31:0] lanes(input logic [31:0] cur, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = cur;
        for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a);
        case (a)
            4'h0:       return 32'h527a_0310;
            4'h1, 4'h2: return {31'b0, m_en};
            4'h3:       return m_pre;
            4'h4:       return m_per;
            4'h5:       return m_cnt;
            4'h6:       return {28'b0, m_inv};
            4'h8, 4'h9, 4'hA, 4'hB: return m_duty[a - 4'h8];
            default:    return 32'h0;
        endcase
    endfunction

    task automatic model_step(input logic r, input logic ck, input logic st, input logic w,
                              input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        logic tick, wrap, frc;
        logic [31:0] v;
        if (r) begin
            m_en = 0; m_pre = 0; m_per = 0; m_pc = 0; m_cnt = 0; a_per = 0;
            m_inv = 0; m_pwm = 0;
            for (int i = 0; i < 4; i++) begin m_duty[i] = 0; a_duty[i] = 0; end
            return;
        end
        tick = m_en && ck && (m_pc == m_pre);
        wrap = tick && (m_cnt == a_per);
        frc  = st && w && (a == 4'h1) && s[0] && d[1];
        if (ck)
            for (int i = 0; i < 4; i++) m_pwm[i] = (m_en && (m_cnt < a_duty[i])) ^ m_inv[i];
        if (wrap || frc || !m_en) begin
            a_per = m_per;
            for (int i = 0; i < 4; i++) a_duty[i] = m_duty[i];
        end
        if (!m_en) begin
            m_pc = 0; m_cnt = 0;
        end else if (ck) begin
            if (tick) begin
                m_pc  = 0;
                m_cnt = wrap ? 0 : m_cnt + 1;
            end else begin
                m_pc = (m_pc + 1) & 32'hFFFF;
            end
        end
        if (st && w) begin
            case (a)
                4'h1: begin v = lanes({31'b0, m_en}, d, s); m_en = v[0]; end
                4'h3: m_pre = lanes(m_pre, d, s) & 32'hFFFF;
                4'h4: m_per = lanes(m_per, d, s) & 32'hFFFF;
                4'h6: begin v = lanes({28'b0, m_inv}, d, s); m_inv = v[3:0]; end
                4'h8, 4'h9, 4'hA, 4'hB: m_duty[a - 4'h8] = lanes(m_duty[a - 4'h8], d, s) & 32'hFFFF;
                default: ;
            endcase
        end
    endtask

    // One bus cycle: drive, check combinational bus outputs, clock, check pin.
    task automatic cyc(input logic r, input logic ck, input logic st, input logic w,
                       input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        reset = r; cke = ck; stb = st; we = w; adr = {12'h0, a}; dat_i = d; sel = s;
        #1;
        check("ack", {31'b0, ack}, {31'b0, st});
        if (st && !w) check($sformatf("rd%0h", a), dat_o, m_read(a));
        @(posedge clk);
        model_step(r, ck, st, w, a, d, s);
        #1;
        check("pwm", {28'b0, pwm}, {28'b0, m_pwm});
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, a, d, 4'hF);
    endtask

    task automatic rd(input logic [3:0] a);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, a, 32'h0, 4'h0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    endtask

    initial begin
        logic [3:0]  ra;
        logic [31:0] rd_v;
        logic [3:0]  rs;
        logic        rck;
        int          op;

        reset = 1; cke = 1; stb = 0; we = 0; adr = 0; dat_i = 0; sel = 0;
        model_step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);

        rd(4'h0); check("id", dat_o, 32'h527a_0310);
        rd(4'h2); check("status0", dat_o, 32'h0);
        rd(4'h5); check("counter0", dat_o, 32'h0);
        check("pwm_rst", {28'b0, pwm}, 32'h0);

        // PRESCALE=0, PERIOD=9, DUTY0=3: 3 high / 7 low
        wr(4'h3, 0); wr(4'h4, 9); wr(4'h8, 3);
        wr(4'h1, 1);
        for (int j = 1; j <= 20; j++) begin
            idle(1);
            check("pat0", {31'b0, pwm[0]}, {31'b0, ((j - 1) % 10) < 3});
        end

        // mid-period duty change, then a duty write on the exact wrap cycle
        idle(4); wr(4'h8, 7);
        idle(12);
        for (int k = 0; k < 25 && m_cnt != 9; k++) idle(1);
        wr(4'h8, 5);
        idle(25);

        // PRESCALE=2, PERIOD=3, DUTY1=2, INVERT=0010, restarted from zero
        wr(4'h3, 2); wr(4'h4, 3); wr(4'h9, 2); wr(4'h6, 4'b0010);
        wr(4'h1, 0); wr(4'h1, 1);
        for (int j = 1; j <= 24; j++) begin
            idle(1);
            check("pat1", {31'b0, pwm[1]}, {31'b0, (((j - 1) / 3) % 4) >= 2});
        end

        // edge duties with PERIOD=4
        wr(4'h4, 4); wr(4'hA, 0); wr(4'hB, 5);
        idle(30);
        for (int j = 0; j < 15; j++) begin
            idle(1);
            check("duty0", {31'b0, pwm[2]}, 32'h0);
            check("dutymax", {31'b0, pwm[3]}, 32'h1);
        end

        // byte-lane write on PERIOD
        wr(4'h4, 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'h4, 32'hFFFF_FFAA, 4'b0001);
        rd(4'h4); check("per_be", dat_o, 32'h0000_00AA);
        wr(4'h4, 4);
        idle(20);

        // cke hold for 5 cycles, reading COUNTER while frozen
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'h5, 32'h0, 4'h0);
        idle(10);

        // enable 1->0
        wr(4'h1, 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'h5, 32'h0, 4'h0);
        check("dis_cnt", dat_o, 32'h0);
        check("dis_pwm", {28'b0, pwm}, 32'h2);

        // randomized traffic
        wr(4'h1, 1);
        for (int n = 0; n < 600; n++) begin
            op  = $urandom_range(0, 9);
            rck = ($urandom_range(0, 7) != 0);
            rs  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            rd_v = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 14);
            case (op)
                0, 1, 2, 3: cyc(1'b0, rck, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
                4, 5: cyc(1'b0, rck, 1'b1, 1'b0, 4'($urandom_range(0, 15)), 32'h0, 4'h0);
                6, 7, 8: begin
                    case ($urandom_range(0, 5))
                        0: ra = 4'h3;
                        1: ra = 4'h4;
                        2: ra = 4'h6;
                        3: ra = 4'($urandom_range(0, 15));
                        default: ra = 4'($urandom_range(8, 11));
                    endcase
                    if (ra == 4'h3) rd_v = rd_v & 32'h3;
                    if (ra == 4'h1) rd_v = 32'h1;
                    cyc(1'b0, rck, 1'b1, 1'b1, ra, rd_v, rs);
                end
                default: begin
                    rd_v = {30'b0, ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) != 0)};
                    cyc(1'b0, rck, 1'b1, 1'b1, 4'h1, rd_v, rs);
                end
            endcase
        end

        // reset mid-operation, with cke low
        wr(4'h1, 1); idle(7);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        for (int k = 0; k < 12; k++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'(k), 32'h0, 4'h0);
            check($sformatf("rst_reg%0h", k), dat_o, (k == 0) ? 32'h527a_0310 : 32'h0);
        end
        check("rst_pwm", {28'b0, pwm}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
